// File: rtl/id_ctrl_flow_pkg.sv
// Shared decode constants and instruction-class helper for the ID-stage control-flow block.
package id_ctrl_flow_pkg;

    localparam logic [5:0]  OP_RTYPE   = 6'h00;
    localparam logic [5:0]  OP_J       = 6'h02;
    localparam logic [5:0]  OP_JAL     = 6'h03;
    localparam logic [5:0]  OP_BEQ     = 6'h04;
    localparam logic [5:0]  OP_BNE     = 6'h05;
    localparam logic [5:0]  OP_SB      = 6'h28;
    localparam logic [5:0]  OP_SH      = 6'h29;
    localparam logic [5:0]  OP_SW      = 6'h2B;
    localparam logic [5:0]  FN_JR      = 6'h08;
    localparam logic [31:0] NOP_WORD_C = 32'h0000_0000;

    typedef struct packed {
        logic is_j;
        logic is_jal;
        logic is_jr;
        logic is_beq;
        logic is_bne;
        logic uses_rt;
    } dec_t;

    function automatic dec_t decode_instr(input logic [31:0] instr);
        dec_t       d;
        logic [5:0] op;
        op        = instr[31:26];
        d.is_j    = (op == OP_J);
        d.is_jal  = (op == OP_JAL);
        d.is_jr   = (op == OP_RTYPE) && (instr[5:0] == FN_JR);
        d.is_beq  = (op == OP_BEQ);
        d.is_bne  = (op == OP_BNE);
        // rt is a true source only for R-type, compare-branches and stores
        d.uses_rt = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) ||
                    (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
        return d;
    endfunction

endpackage

// File: rtl/id_ctrl_flow_if.sv
// Fetch <-> ID control-flow handshake: fetched word in, redirect and stall back to fetch.
interface id_ctrl_flow_if;
    logic [31:0] Instruction_if;
    logic [31:0] PC_if;
    logic        IF_flush;
    logic        Branch;
    logic        Jump;
    logic [31:0] JumpAddr;
    logic        IFWrite;

    modport master (
        output Instruction_if, PC_if, IF_flush,
        input  Branch, Jump, JumpAddr, IFWrite
    );

    modport slave (
        input  Instruction_if, PC_if, IF_flush,
        output Branch, Jump, JumpAddr, IFWrite
    );
endinterface

// File: rtl/id_ctrl_flow_hazard.sv
// Combinational hazard detect: load-use against EX, and branch-operand against EX writers / MEM loads.
module id_hazard_detect
    import id_ctrl_flow_pkg::*;
(
    input  logic       valid_i,
    input  dec_t       dec_i,
    input  logic [4:0] rs_addr_i,
    input  logic [4:0] rt_addr_i,
    input  logic       ex_RegWrite,
    input  logic       ex_MemRead,
    input  logic [4:0] ex_wreg,
    input  logic       mem_MemRead,
    input  logic [4:0] mem_wreg,
    output logic       hz_o
);

    logic ex_match_s;
    logic mem_match_s;
    logic br_src_s;
    logic load_use_s;
    logic br_hz_s;

    // Source match per stage and hazard combine
    always_comb begin
        br_src_s    = dec_i.is_beq | dec_i.is_bne | dec_i.is_jr;
        ex_match_s  = (ex_wreg != 5'd0) &&
                      ((ex_wreg == rs_addr_i) || (dec_i.uses_rt && (ex_wreg == rt_addr_i)));
        mem_match_s = (mem_wreg != 5'd0) &&
                      ((mem_wreg == rs_addr_i) || (dec_i.uses_rt && (mem_wreg == rt_addr_i)));
        load_use_s  = ex_MemRead & ex_match_s;
        br_hz_s     = br_src_s & ((ex_RegWrite & ex_match_s) | (mem_MemRead & mem_match_s));
        hz_o        = valid_i & (load_use_s | br_hz_s);
    end

endmodule

// File: rtl/id_ctrl_flow.sv
// ID-stage front end: IF/ID register, J/JAL/JR/BEQ/BNE resolution and stall/bubble control.
// Optional build macro ID_PERF_CNT_EN adds stall/redirect counters; otherwise they read 0.
module id_ctrl_flow
    import id_ctrl_flow_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = NOP_WORD_C
) (
    input  logic          clk,
    input  logic          reset,
    id_ctrl_flow_if.slave fetch,
    input  logic [31:0]   rs_data,
    input  logic [31:0]   rt_data,
    input  logic          ex_RegWrite,
    input  logic          ex_MemRead,
    input  logic [4:0]    ex_wreg,
    input  logic          mem_MemRead,
    input  logic [4:0]    mem_wreg,
    output logic [31:0]   Instruction_id,
    output logic [31:0]   PC4_id,
    output logic [4:0]    rs_addr,
    output logic [4:0]    rt_addr,
    output logic          bubble_id,
    output logic [31:0]   stall_cnt,
    output logic [31:0]   flush_cnt
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic        hz_s;
    logic        ifwrite_s;
    logic        branch_s;
    logic        jump_s;
    logic [31:0] br_tgt_s;
    logic [31:0] jaddr_s;
    dec_t        dec_s;

    assign dec_s = decode_instr(instr_q);

    id_hazard_detect u_hazard (
        .valid_i     (valid_q),
        .dec_i       (dec_s),
        .rs_addr_i   (instr_q[25:21]),
        .rt_addr_i   (instr_q[20:16]),
        .ex_RegWrite (ex_RegWrite),
        .ex_MemRead  (ex_MemRead),
        .ex_wreg     (ex_wreg),
        .mem_MemRead (mem_MemRead),
        .mem_wreg    (mem_wreg),
        .hz_o        (hz_s)
    );

    // IF/ID next state: flush beats load, load beats hold
    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (fetch.IF_flush) begin
            instr_d = NOP_WORD;
            pc4_d   = pc4_q;
            valid_d = 1'b0;
        end else if (ifwrite_s) begin
            instr_d = fetch.Instruction_if;
            pc4_d   = fetch.PC_if + 32'd4;
            valid_d = 1'b1;
        end else begin
            instr_d = instr_q;
        end
    end

    // IF/ID register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= NOP_WORD;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    // Redirect resolution; a pending hazard suppresses any redirect this cycle
    always_comb begin
        br_tgt_s = pc4_q + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        branch_s = valid_q & ~hz_s &
                   ((dec_s.is_beq & (rs_data == rt_data)) |
                    (dec_s.is_bne & (rs_data != rt_data)));
        jump_s   = valid_q & ~hz_s & (dec_s.is_j | dec_s.is_jal | dec_s.is_jr);
        if (branch_s) begin
            jaddr_s = br_tgt_s;
        end else if (jump_s && dec_s.is_jr) begin
            jaddr_s = rs_data;
        end else if (jump_s) begin
            jaddr_s = {pc4_q[31:28], instr_q[25:0], 2'b00};
        end else begin
            jaddr_s = 32'd0;
        end
    end

    assign ifwrite_s      = ~hz_s;
    assign fetch.IFWrite  = ifwrite_s;
    assign fetch.Branch   = branch_s;
    assign fetch.Jump     = jump_s;
    assign fetch.JumpAddr = jaddr_s;
    assign Instruction_id = instr_q;
    assign PC4_id         = pc4_q;
    assign rs_addr        = instr_q[25:21];
    assign rt_addr        = instr_q[20:16];
    assign bubble_id      = hz_s | ~valid_q;

`ifdef ID_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Counter increments, wrapping naturally at 2^32
    always_comb begin
        stall_cnt_d = hz_s ? (stall_cnt_q + 32'd1) : stall_cnt_q;
        flush_cnt_d = (branch_s | jump_s) ? (flush_cnt_q + 32'd1) : flush_cnt_q;
    end

    // Performance counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule
